// File: rtl/seven_display.sv
// Four-digit multiplexed hex driver for a common-anode seven-segment display.
// Registered decoder: anode and cathode patterns are captured together on each CLK edge.
module seven_display #(
  parameter logic [3:0] DP_MASK = 4'b0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  SCLK,
  input  logic [15:0] DISPLAY,
  output logic [7:0]  SSEG_CA,
  output logic [3:0]  SSEG_AN
);

  logic [3:0] nib;
  logic [6:0] seg;
  logic [7:0] ca_d;
  logic [3:0] an_d;

  // Active-low segments {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] s;
    unique case (val)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    nib  = 4'h0;
    an_d = 4'hF;
    unique case (SCLK)
      2'd0: begin
        nib  = DISPLAY[3:0];
        an_d = 4'b1110;
      end
      2'd1: begin
        nib  = DISPLAY[7:4];
        an_d = 4'b1101;
      end
      2'd2: begin
        nib  = DISPLAY[11:8];
        an_d = 4'b1011;
      end
      2'd3: begin
        nib  = DISPLAY[15:12];
        an_d = 4'b0111;
      end
      default: begin
        nib  = 4'h0;
        an_d = 4'hF;
      end
    endcase
    seg  = hex_to_seg(nib);
    ca_d = {~DP_MASK[SCLK], seg};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SSEG_CA <= 8'hFF;
      SSEG_AN <= 4'hF;
    end else begin
      SSEG_CA <= ca_d;
      SSEG_AN <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_display.sv
// Self-checking bench for seven_display: vector table driven through a one-cycle scoreboard,
// plus hand-written reset, latency and decimal-point sequences.
module tb_seven_display;

  logic        CLK;
  logic        RST_N;
  logic [1:0]  SCLK;
  logic [15:0] DISPLAY;
  logic [7:0]  ca, ca_dp;
  logic [3:0]  an, an_dp;

  int n_vec  = 0;
  int n_miss = 0;

  seven_display u_dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SCLK    (SCLK),
    .DISPLAY (DISPLAY),
    .SSEG_CA (ca),
    .SSEG_AN (an)
  );

  seven_display #(.DP_MASK(4'b0100)) u_dut_dp (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SCLK    (SCLK),
    .DISPLAY (DISPLAY),
    .SSEG_CA (ca_dp),
    .SSEG_AN (an_dp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sclk;
    logic [15:0] disp;
    logic [3:0]  an;
    logic [7:0]  ca;
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  an;
    logic [7:0]  ca;
    logic [7:0]  ca_dp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [7:0] glyph [16];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %01h expected %01h", name, act, exp);
    end
  endtask

  // Independent model of the masked instance: only the dp bit differs from the table value.
  function automatic logic [7:0] dp_model(input logic [1:0] s, input logic [7:0] ca_exp);
    logic [3:0] mask;
    mask = 4'b0100;
    return {~mask[s], ca_exp[6:0]};
  endfunction

  task automatic apply(input string name, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] exp_an, input logic [7:0] exp_ca);
    exp_t e;
    @(negedge CLK);
    SCLK    = s;
    DISPLAY = d;
    e.name  = name;
    e.an    = exp_an;
    e.ca    = exp_ca;
    e.ca_dp = dp_model(s, exp_ca);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, got an=%01h ca=%02h", name, an, ca);
    end else begin
      e = sb.pop_front();
      check4({e.name, ".an"}, an, e.an);
      check8({e.name, ".ca"}, ca, e.ca);
      check4({e.name, ".an_dp"}, an_dp, e.an);
      check8({e.name, ".ca_dp"}, ca_dp, e.ca_dp);
    end
  endtask

  initial begin
    glyph[0]  = 8'hC0; glyph[1]  = 8'hF9; glyph[2]  = 8'hA4; glyph[3]  = 8'hB0;
    glyph[4]  = 8'h99; glyph[5]  = 8'h92; glyph[6]  = 8'h82; glyph[7]  = 8'hF8;
    glyph[8]  = 8'h80; glyph[9]  = 8'h90; glyph[10] = 8'h88; glyph[11] = 8'h83;
    glyph[12] = 8'hC6; glyph[13] = 8'hA1; glyph[14] = 8'h86; glyph[15] = 8'h8E;

    vecs.push_back('{2'd0, 16'h1234, 4'hE, 8'h99});
    vecs.push_back('{2'd1, 16'h1234, 4'hD, 8'hB0});
    vecs.push_back('{2'd2, 16'h1234, 4'hB, 8'hA4});
    vecs.push_back('{2'd3, 16'h1234, 4'h7, 8'hF9});
    vecs.push_back('{2'd0, 16'hBEEF, 4'hE, 8'h8E});
    vecs.push_back('{2'd3, 16'hBEEF, 4'h7, 8'h83});
    vecs.push_back('{2'd1, 16'hBEEF, 4'hD, 8'h86});
    for (int x = 0; x < 16; x++)
      vecs.push_back('{2'd0, {12'h000, 4'(x)}, 4'hE, glyph[x]});

    RST_N   = 1'b0;
    SCLK    = 2'd2;
    DISPLAY = 16'h1234;
    #12;
    check8("reset.ca", ca, 8'hFF);
    check4("reset.an", an, 4'hF);
    @(posedge CLK);
    #1;
    check8("reset_held.ca", ca, 8'hFF);
    check4("reset_held.an", an, 4'hF);

    // Release away from the edge; the first edge must show the sampled SCLK/DISPLAY.
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check4("first_edge.an", an, 4'hB);
    check8("first_edge.ca", ca, 8'hA4);

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].sclk, vecs[i].disp, vecs[i].an, vecs[i].ca);

    // Latency: DISPLAY change between edges is invisible until the next edge.
    apply("lat_a", 2'd3, 16'hA000, 4'h7, 8'h88);
    @(negedge CLK);
    DISPLAY = 16'hF000;
    #1;
    check8("lat_hold.ca", ca, 8'h88);
    check4("lat_hold.an", an, 4'h7);
    @(posedge CLK);
    #1;
    check8("lat_new.ca", ca, 8'h8E);
    check4("lat_new.an", an, 4'h7);

    // Decimal point on digit 2 of the masked instance only.
    apply("dp_on", 2'd2, 16'h0800, 4'hB, 8'h80);
    check8("dp_on.abs", ca_dp, 8'h00);
    apply("dp_off", 2'd1, 16'h0800, 4'hD, 8'hC0);
    check8("dp_off.abs", ca_dp, 8'hC0);

    // Asynchronous reset mid-operation, checked before any clock edge.
    apply("pre_rst", 2'd2, 16'h1234, 4'hB, 8'hA4);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check8("async_rst.ca", ca, 8'hFF);
    check4("async_rst.an", an, 4'hF);
    check8("async_rst.ca_dp", ca_dp, 8'hFF);
    #5;
    RST_N = 1'b1;
    apply("post_rst", 2'd0, 16'h1234, 4'hE, 8'h99);

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
